// File: rtl/pipe_skid_stage_pkg.sv
// Shared core definitions for valid/ready handshake stages.
package pipe_skid_stage_pkg;

  // Occupancy state of a two-slot handshake stage; encoding equals entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Number of held entries for a given occupancy state.
  function automatic logic [1:0] state_count(input skid_state_e s);
    logic [1:0] n;
    case (s)
      ST_EMPTY: n = 2'd0;
      ST_ONE:   n = 2'd1;
      ST_FULL:  n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-slot skid buffer: fully registered valid/ready pipeline stage.
// MAIN drives out_data; SKID catches the entry accepted while MAIN stalls.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned      DATAW     = 32,
  parameter logic [DATAW-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic [DATAW-1:0] r_main;
  logic [DATAW-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_ld_in;
  logic w_main_ld_skid;
  logic w_skid_ld;

  // Handshake outputs depend on state flops only, never on out_ready/in_valid.
  assign in_ready   = (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign count      = state_count(r_state);

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Next-state and slot-load decode; flush only clears state, slots keep contents.
  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_ld_in = 1'b1;
            w_state_nxt  = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({w_in_fire, w_out_fire})
            2'b11: w_main_ld_in = 1'b1;
            2'b10: begin
              w_skid_ld   = 1'b1;
              w_state_nxt = ST_FULL;
            end
            2'b01: w_state_nxt = ST_EMPTY;
            default: ;
          endcase
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_ld_skid = 1'b1;
            w_state_nxt    = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data slots: MAIN takes new input or the skid entry, SKID takes overflow input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= RST_VALUE;
      r_skid <= RST_VALUE;
    end else begin
      if (w_main_ld_in) begin
        r_main <= in_data;
      end else if (w_main_ld_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_ld) begin
        r_skid <= in_data;
      end
    end
  end

endmodule
